// File: rtl/shift_sched_ctrl_pkg.sv
// shift_sched_ctrl_pkg: FSM state encoding and requester index constants shared by the shift scheduler
package shift_sched_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2} state_t;
  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;
endpackage

// File: rtl/shift_sched_ctrl_rr_arb2.sv
// rr_arb2: 2-way round-robin arbiter; req[1:0] in, one-hot gnt[1:0] out, last_grant updated when accept is high
module rr_arb2
  import shift_sched_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);
  logic last;
  always_comb gnt = &req ? (last ? 2'b01 : 2'b10) : req;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= SRC1;
    else if (accept) last <= gnt[1];
endmodule

// File: rtl/shift_sched_ctrl.sv
// shift_sched_ctrl: round-robin shared left-shifter; req0/req1 valid-ready commands in, rsp valid-ready result with source tag out, busy in SHIFT/DONE
module shift_sched_ctrl
  import shift_sched_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 2,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [AMT_W-1:0] req1_amt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_src,
  output logic             busy
);
  state_t state, state_nx;
  logic [1:0] idle_req, gnt;
  logic accept, sel;
  logic [AMT_W-1:0] amt, cnt;
  logic [WIDTH-1:0] sr;
  logic src;
  assign idle_req = state == ST_IDLE ? {req1_valid, req0_valid} : 2'b00;
  rr_arb2 u_arb (.clk, .rst_n, .req(idle_req), .accept, .gnt);
  assign accept = |gnt;
  assign sel = gnt[1];
  assign amt = sel ? req1_amt : req0_amt;
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign rsp_valid = state == ST_DONE;
  assign busy = state != ST_IDLE;
  assign rsp_data = sr;
  assign rsp_src = src;
  always_comb begin
    state_nx = state;
    if (state == ST_IDLE && accept) state_nx = amt == '0 ? ST_DONE : ST_SHIFT;
    else if (state == ST_SHIFT && cnt == AMT_W'(1)) state_nx = ST_DONE;
    else if (state == ST_DONE && rsp_ready) state_nx = ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      sr <= '0;
      cnt <= '0;
      src <= SRC0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && accept) begin
        sr <= sel ? req1_data : req0_data;
        cnt <= amt;
        src <= sel;
      end else if (state == ST_SHIFT) begin
        sr <= {sr[WIDTH-STEP-1:0], {STEP{1'b0}}};
        cnt <= cnt - AMT_W'(1);
      end
    end
endmodule
